btn_gesture_decoder: RTL and testbench



---
 rtl/btn_gesture_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_btn_gesture_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_gesture_decoder.sv
// rtl/btn_gesture_decoder.sv - push-button debouncer and gesture decoder
//
// Turns a raw, bouncy, asynchronous push-button into a clean debounced level
// and one-cycle gesture events.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active high
//   btn           raw button input, asynchronous, active high
//   pressed       debounced button level
//   short_press   one-cycle pulse: single click, GAP_CYCLES after release
//   double_press  one-cycle pulse: second click released within the gap
//   long_press    one-cycle pulse: first press held LONG_CYCLES
//   repeat_press  one-cycle pulse every REPEAT_CYCLES while a long press is held
//
// All event outputs are registered and mutually exclusive.

module btn_gesture_decoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 1000,
  parameter int GAP_CYCLES      = 250,
  parameter int REPEAT_CYCLES   = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pressed,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_press
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(LONG_CYCLES) + 1;
  localparam int GAP_W  = $clog2(GAP_CYCLES) + 1;
  localparam int REP_W  = $clog2(REPEAT_CYCLES) + 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_WAIT2,
    S_PRESS2,
    S_HOLD
  } state_t;

  // ---------------------------------------------------------------------
  // Two-flop synchronizer
  // ---------------------------------------------------------------------
  logic btn_meta;
  logic btn_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

  // ---------------------------------------------------------------------
  // Debounce: the synced level must disagree with `pressed` for
  // DEBOUNCE_CYCLES consecutive cycles before `pressed` follows it.
  // Any agreement in between restarts the count, so short glitches vanish.
  // ---------------------------------------------------------------------
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt  <= '0;
      pressed <= 1'b0;
    end else if (btn_sync != pressed) begin
      if (db_cnt >= DB_LAST) begin
        pressed <= btn_sync;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------
  // Gesture FSM, driven only by the debounced level.
  //
  // hold_cnt counts debounced-high cycles of the first press, including the
  // IDLE cycle that observed the rise, so long_press lands LONG_CYCLES after
  // `pressed` rose. gap_cnt likewise counts low cycles since the release,
  // starting with the PRESS1 cycle that observed the fall. rep_cnt counts
  // cycles since the last long/repeat pulse. Each counter only increments
  // while below its terminal value, so none of them can wrap.
  // ---------------------------------------------------------------------
  state_t             state;
  state_t             state_nxt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HOLD_W-1:0]  hold_nxt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [GAP_W-1:0]   gap_nxt;
  logic [REP_W-1:0]   rep_cnt;
  logic [REP_W-1:0]   rep_nxt;
  logic               short_nxt;
  logic               double_nxt;
  logic               long_nxt;
  logic               repeat_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      hold_cnt     <= '0;
      gap_cnt      <= '0;
      rep_cnt      <= '0;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      repeat_press <= 1'b0;
    end else begin
      state        <= state_nxt;
      hold_cnt     <= hold_nxt;
      gap_cnt      <= gap_nxt;
      rep_cnt      <= rep_nxt;
      short_press  <= short_nxt;
      double_press <= double_nxt;
      long_press   <= long_nxt;
      repeat_press <= repeat_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    gap_nxt    = gap_cnt;
    rep_nxt    = rep_cnt;
    short_nxt  = 1'b0;
    double_nxt = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (pressed) begin
          state_nxt = S_PRESS1;
          hold_nxt  = HOLD_W'(1);
        end
      end

      S_PRESS1: begin
        if (!pressed) begin
          state_nxt = S_WAIT2;
          gap_nxt   = GAP_W'(1);
        end else if (hold_cnt >= HOLD_LAST) begin
          long_nxt  = 1'b1;
          state_nxt = S_HOLD;
          rep_nxt   = '0;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end

      S_WAIT2: begin
        // A rise seen while the gap is still open beats an expiry due on
        // the same edge; once the gap has expired we have already left.
        if (pressed) begin
          state_nxt = S_PRESS2;
        end else if (gap_cnt >= GAP_LAST) begin
          short_nxt = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end

      S_PRESS2: begin
        if (!pressed) begin
          double_nxt = 1'b1;
          state_nxt  = S_IDLE;
        end
      end

      S_HOLD: begin
        // Release wins over a repeat due on the same edge.
        if (!pressed) begin
          state_nxt = S_IDLE;
        end else if (rep_cnt >= REP_LAST) begin
          repeat_nxt = 1'b1;
          rep_nxt    = '0;
        end else begin
          rep_nxt = rep_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_gesture_decoder.sv
// tb/tb_btn_gesture_decoder.sv - directed self-checking bench for btn_gesture_decoder

module tb_btn_gesture_decoder;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic pressed;
  logic short_press;
  logic double_press;
  logic long_press;
  logic repeat_press;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  btn_gesture_decoder #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .GAP_CYCLES     (10),
    .REPEAT_CYCLES  (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .pressed     (pressed),
    .short_press (short_press),
    .double_press(double_press),
    .long_press  (long_press),
    .repeat_press(repeat_press)
  );

  // Leaves the bench 1 time unit after a reset edge; that edge is "edge 0"
  // for the scenario tasks, which then drive btn for the following cycle.
  task automatic apply_reset();
    rst = 1'b1;
    btn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    rst = 1'b1;
    btn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    obs = {pressed, short_press, double_press, long_press, repeat_press};
    n_vec++;
    if (obs !== 5'b00000) begin
      n_miss++;
      $display("FAIL reset_idle: got %b want %b", obs, 5'b00000);
    end
    rst = 1'b0;
    btn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_vec++;
    if (pressed !== 1'b1) begin
      n_miss++;
      $display("FAIL reset_pre_pressed: got %b want %b", pressed, 1'b1);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    obs = {pressed, short_press, double_press, long_press, repeat_press};
    n_vec++;
    if (obs !== 5'b00000) begin
      n_miss++;
      $display("FAIL reset_while_pressed: got %b want %b", obs, 5'b00000);
    end
    btn = 1'b0;
  endtask

  task automatic test_bounce();
    logic [4:0] obs;
    logic [4:0] exp;
    apply_reset();
    btn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      obs = {pressed, short_press, double_press, long_press, repeat_press};
      exp = {(k >= 8), 1'b0, 1'b0, 1'b0, 1'b0};
      n_vec++;
      if (obs !== exp) begin
        n_miss++;
        $display("FAIL bounce k=%0d: got %b want %b", k, obs, exp);
      end
      btn = (k != 1);
    end
  endtask

  task automatic test_single_click();
    logic [4:0] obs;
    logic [4:0] exp;
    apply_reset();
    btn = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      obs = {pressed, short_press, double_press, long_press, repeat_press};
      exp = {(k >= 6 && k < 14), (k == 24), 1'b0, 1'b0, 1'b0};
      n_vec++;
      if (obs !== exp) begin
        n_miss++;
        $display("FAIL single_click k=%0d: got %b want %b", k, obs, exp);
      end
      btn = (k < 8);
    end
  endtask

  task automatic test_double_click();
    logic [4:0] obs;
    logic [4:0] exp;
    apply_reset();
    btn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      obs = {pressed, short_press, double_press, long_press, repeat_press};
      exp = {((k >= 6 && k < 11) || (k >= 17 && k < 22)), 1'b0, (k == 23), 1'b0, 1'b0};
      n_vec++;
      if (obs !== exp) begin
        n_miss++;
        $display("FAIL double_click k=%0d: got %b want %b", k, obs, exp);
      end
      btn = (k < 5) || (k >= 11 && k < 16);
    end
  endtask

  task automatic test_long_hold();
    logic [4:0] obs;
    logic [4:0] exp;
    apply_reset();
    btn = 1'b1;
    for (int k = 1; k <= 75; k++) begin
      @(posedge clk);
      #1;
      obs = {pressed, short_press, double_press, long_press, repeat_press};
      exp = {(k >= 6 && k < 56), 1'b0, 1'b0, (k == 26),
             (k >= 31 && k <= 56 && ((k - 31) % 5) == 0)};
      n_vec++;
      if (obs !== exp) begin
        n_miss++;
        $display("FAIL long_hold k=%0d: got %b want %b", k, obs, exp);
      end
      btn = (k < 50);
    end
  endtask

  task automatic test_gap_expiry();
    logic [4:0] obs;
    logic [4:0] exp;
    apply_reset();
    btn = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #1;
      obs = {pressed, short_press, double_press, long_press, repeat_press};
      exp = {((k >= 6 && k < 11) || k >= 23), (k == 21), 1'b0, (k == 43), (k == 48)};
      n_vec++;
      if (obs !== exp) begin
        n_miss++;
        $display("FAIL gap_expiry k=%0d: got %b want %b", k, obs, exp);
      end
      btn = (k < 5) || (k >= 17);
    end
    btn = 1'b0;
  endtask

  task automatic test_gap_boundary();
    logic [4:0] obs;
    logic [4:0] exp;
    apply_reset();
    btn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      obs = {pressed, short_press, double_press, long_press, repeat_press};
      exp = {((k >= 6 && k < 11) || (k >= 20 && k < 25)), 1'b0, (k == 26), 1'b0, 1'b0};
      n_vec++;
      if (obs !== exp) begin
        n_miss++;
        $display("FAIL gap_boundary k=%0d: got %b want %b", k, obs, exp);
      end
      btn = (k < 5) || (k >= 14 && k < 19);
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [4:0] obs;
    logic [4:0] exp;
    apply_reset();
    btn = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      @(posedge clk);
      #1;
      obs = {pressed, short_press, double_press, long_press, repeat_press};
      exp = {((k >= 6 && k < 22) || k >= 28), 1'b0, 1'b0, (k == 48), (k == 53)};
      n_vec++;
      if (obs !== exp) begin
        n_miss++;
        $display("FAIL reset_mid_hold k=%0d: got %b want %b", k, obs, exp);
      end
      rst = (k == 21);
    end
    btn = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    test_reset();
    test_bounce();
    test_single_click();
    test_double_click();
    test_long_hold();
    test_gap_expiry();
    test_gap_boundary();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
